// File: rtl/rf_pkg.sv
// Shared types and helpers for the multi-port register file.
// Optional same-cycle write->read forwarding is enabled by defining RF_BYPASS_EN.
package rf_pkg;

    function automatic int unsigned rf_aw(input int unsigned n);
        return $clog2(n);
    endfunction

    localparam int unsigned RF_XLEN  = 32;
    localparam int unsigned RF_NREGS = 32;
    localparam int unsigned RF_AW    = rf_aw(RF_NREGS);

    typedef logic [RF_AW-1:0]   rf_addr_t;
    typedef logic [RF_XLEN-1:0] rf_word_t;

    localparam rf_addr_t RF_ZERO_REG = '0;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending scoreboard: alloc sets, any writeback lane clears, set wins.
// x0 is never pending.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned NREGS = 32,
    parameter int unsigned NWR   = 2,
    parameter int unsigned AW    = rf_aw(NREGS)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NWR-1:0]    wr_en_i,
    input  logic [NWR*AW-1:0] wr_addr_i,
    input  logic              alloc_en_i,
    input  logic [AW-1:0]     alloc_addr_i,
    output logic [NREGS-1:0]  pending_o
);

    logic [NREGS-1:0] pending_q, pending_d;

    always_comb begin
        logic set_r;
        logic clr_r;
        pending_d = pending_q;
        set_r     = 1'b0;
        clr_r     = 1'b0;
        for (int r = 1; r < int'(NREGS); r++) begin
            set_r = alloc_en_i && (alloc_addr_i == AW'(r));
            clr_r = 1'b0;
            for (int l = 0; l < int'(NWR); l++) begin
                if (wr_en_i[l] && (wr_addr_i[l*AW +: AW] == AW'(r))) begin
                    clr_r = 1'b1;
                end
            end
            // A new producer issued while the old one retires keeps the register pending.
            if (set_r) begin
                pending_d[r] = 1'b1;
            end else if (clr_r) begin
                pending_d[r] = 1'b0;
            end
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with pending scoreboard; x0 hardwired to zero.
// Define RF_BYPASS_EN for same-cycle write->read forwarding on every read port.
module regfile_mp
    import rf_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 3,
    parameter int unsigned NWR   = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NRD*rf_aw(NREGS)-1:0]          rs_addr_i,
    output logic [NRD*XLEN-1:0]                  rs_data_o,
    output logic [NRD-1:0]                       rs_busy_o,
    input  logic [NWR-1:0]                       wr_en_i,
    input  logic [NWR*rf_aw(NREGS)-1:0]          wr_addr_i,
    input  logic [NWR*XLEN-1:0]                  wr_data_i,
    input  logic                                 alloc_en_i,
    input  logic [rf_aw(NREGS)-1:0]              alloc_addr_i,
    output logic [NREGS-1:0]                     pending_vec_o
);

    localparam int unsigned AW = rf_aw(NREGS);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] pending;

    rf_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR),
        .AW    (AW)
    ) u_scoreboard (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .wr_en_i      (wr_en_i),
        .wr_addr_i    (wr_addr_i),
        .alloc_en_i   (alloc_en_i),
        .alloc_addr_i (alloc_addr_i),
        .pending_o    (pending)
    );

    assign pending_vec_o = pending;

    // Lanes applied in ascending order so the highest-indexed lane wins a conflict.
    always_comb begin
        logic [AW-1:0] wa;
        regs_d = regs_q;
        wa     = '0;
        for (int l = 0; l < int'(NWR); l++) begin
            wa = wr_addr_i[l*AW +: AW];
            if (wr_en_i[l] && (wa != '0)) begin
                regs_d[wa] = wr_data_i[l*XLEN +: XLEN];
            end
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rd;
        logic            rb;
        rs_data_o = '0;
        rs_busy_o = '0;
        ra        = '0;
        rd        = '0;
        rb        = 1'b0;
        for (int p = 0; p < int'(NRD); p++) begin
            ra = rs_addr_i[p*AW +: AW];
            rd = regs_q[ra];
            rb = pending[ra];
`ifdef RF_BYPASS_EN
            for (int l = 0; l < int'(NWR); l++) begin
                if (wr_en_i[l] && (wr_addr_i[l*AW +: AW] == ra)) begin
                    rd = wr_data_i[l*XLEN +: XLEN];
                    rb = alloc_en_i && (alloc_addr_i == ra);
                end
            end
`endif
            if (ra == '0) begin
                rd = '0;
                rb = 1'b0;
            end
            rs_data_o[p*XLEN +: XLEN] = rd;
            rs_busy_o[p]              = rb;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus a random soak against a
// behavioural model of the register file and scoreboard.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int NRD   = 3;
    localparam int NWR   = 2;

    logic                clk;
    logic                rst_n;
    logic [AW-1:0]       rd_a [NRD];
    logic                we   [NWR];
    logic [AW-1:0]       wa   [NWR];
    logic [XLEN-1:0]     wd   [NWR];
    logic                al_en;
    logic [AW-1:0]       al_a;

    logic [NRD*AW-1:0]   rs_addr;
    logic [NRD*XLEN-1:0] rs_data;
    logic [NRD-1:0]      rs_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic [NREGS-1:0]    pending_vec;

    assign rs_addr = {rd_a[2], rd_a[1], rd_a[0]};
    assign wr_en   = {we[1], we[0]};
    assign wr_addr = {wa[1], wa[0]};
    assign wr_data = {wd[1], wd[0]};

    regfile_mp #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .rs_addr_i     (rs_addr),
        .rs_data_o     (rs_data),
        .rs_busy_o     (rs_busy),
        .wr_en_i       (wr_en),
        .wr_addr_i     (wr_addr),
        .wr_data_i     (wr_data),
        .alloc_en_i    (al_en),
        .alloc_addr_i  (al_a),
        .pending_vec_o (pending_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [XLEN-1:0] m_reg  [NREGS];
    bit              m_pend [NREGS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural state after each accepted edge.
    always @(negedge rst_n) begin
        for (int i = 0; i < NREGS; i++) begin
            m_reg[i]  = '0;
            m_pend[i] = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            for (int l = 0; l < NWR; l++) begin
                if (we[l] && wa[l] != 0) begin
                    m_reg[wa[l]]  = wd[l];
                    m_pend[wa[l]] = 1'b0;
                end
            end
            if (al_en && al_a != 0) m_pend[al_a] = 1'b1;
        end
    end

    // Compare process: outputs vs. model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int p = 0; p < NRD; p++) begin
                logic [XLEN-1:0] ed;
                logic            eb;
                ed = m_reg[rd_a[p]];
                eb = m_pend[rd_a[p]];
`ifdef RF_BYPASS_EN
                for (int l = 0; l < NWR; l++) begin
                    if (we[l] && wa[l] == rd_a[p]) begin
                        ed = wd[l];
                        eb = al_en && al_a == rd_a[p];
                    end
                end
`endif
                if (rd_a[p] == 0) begin
                    ed = '0;
                    eb = 1'b0;
                end
                check($sformatf("model rs_data[%0d]", p), rs_data[p*XLEN +: XLEN], ed);
                check($sformatf("model rs_busy[%0d]", p), {31'd0, rs_busy[p]}, {31'd0, eb});
            end
            for (int r = 0; r < NREGS; r++) begin
                check($sformatf("model pending[%0d]", r), {31'd0, pending_vec[r]},
                      {31'd0, m_pend[r]});
            end
            assert (pending_vec[0] === 1'b0)
            else begin
                errors++;
                $display("FAIL pending0_assert: got %b, expected 0", pending_vec[0]);
            end
        end
    end

    task automatic idle();
        for (int l = 0; l < NWR; l++) begin
            we[l] = 1'b0;
            wa[l] = '0;
            wd[l] = '0;
        end
        al_en = 1'b0;
        al_a  = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [XLEN-1:0] port_data(input int p);
        return rs_data[p*XLEN +: XLEN];
    endfunction

    initial begin
        for (int i = 0; i < NREGS; i++) begin
            m_reg[i]  = '0;
            m_pend[i] = 1'b0;
        end
        rst_n = 1'b0;
        idle();
        for (int p = 0; p < NRD; p++) rd_a[p] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        #1;
        check("reset pending_vec", pending_vec, 32'd0);
        check("reset rs_busy", {29'd0, rs_busy}, 32'd0);

        // 1: reset mid-run
        cyc();
        we[0] = 1'b1; wa[0] = 5'd5; wd[0] = 32'hDEAD_BEEF;
        al_en = 1'b1; al_a = 5'd6;
        rd_a[0] = 5'd5; rd_a[1] = 5'd6;
        cyc();
        idle();
        #1;
        check("t1 x5 written", port_data(0), 32'hDEAD_BEEF);
        check("t1 x6 pending", {31'd0, pending_vec[6]}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("t1 x5 in reset", port_data(0), 32'd0);
        check("t1 pending in reset", pending_vec, 32'd0);
        rst_n = 1'b1;
        cyc();
        check("t1 x5 after reset", port_data(0), 32'd0);
        check("t1 pending after reset", pending_vec, 32'd0);

        // 2: x0 protection
        we[0] = 1'b1; wa[0] = 5'd0; wd[0] = 32'hFFFF_FFFF;
        al_en = 1'b1; al_a = 5'd0;
        rd_a[0] = 5'd0; rd_a[1] = 5'd0; rd_a[2] = 5'd0;
        #1;
        check("t2 x0 data same cycle", port_data(0), 32'd0);
        cyc();
        idle();
        #1;
        check("t2 x0 data", port_data(0), 32'd0);
        check("t2 x0 busy", {31'd0, rs_busy[0]}, 32'd0);
        check("t2 pending[0]", {31'd0, pending_vec[0]}, 32'd0);

        // 3: lane conflict
        cyc();
        we[0] = 1'b1; wa[0] = 5'd7; wd[0] = 32'h1111;
        we[1] = 1'b1; wa[1] = 5'd7; wd[1] = 32'h2222;
        for (int p = 0; p < NRD; p++) rd_a[p] = 5'd7;
        cyc();
        idle();
        #1;
        for (int p = 0; p < NRD; p++) check($sformatf("t3 x7 port%0d", p), port_data(p), 32'h2222);

        // 4: set beats clear
        cyc();
        al_en = 1'b1; al_a = 5'd9;
        rd_a[0] = 5'd9;
        cyc();
        we[0] = 1'b1; wa[0] = 5'd9; wd[0] = 32'h55;
        cyc();
        idle();
        #1;
        check("t4 x9 data", port_data(0), 32'h55);
        check("t4 pending[9] held", {31'd0, pending_vec[9]}, 32'd1);
        we[1] = 1'b1; wa[1] = 5'd9; wd[1] = 32'h66;
        cyc();
        idle();
        #1;
        check("t4 pending[9] cleared", {31'd0, pending_vec[9]}, 32'd0);
        check("t4 x9 data2", port_data(0), 32'h66);

        // 5: write->read with x3 pending (old value 0x1234)
        cyc();
        we[0] = 1'b1; wa[0] = 5'd3; wd[0] = 32'h1234;
        al_en = 1'b1; al_a = 5'd3;
        cyc();
        idle();
        rd_a[2] = 5'd3;
        we[1] = 1'b1; wa[1] = 5'd3; wd[1] = 32'hABCD;
        #1;
`ifdef RF_BYPASS_EN
        check("t5 bypass data", port_data(2), 32'hABCD);
        check("t5 bypass busy", {31'd0, rs_busy[2]}, 32'd0);
`else
        check("t5 old data", port_data(2), 32'h1234);
        check("t5 old busy", {31'd0, rs_busy[2]}, 32'd1);
`endif
        cyc();
        idle();
        #1;
        check("t5 next data", port_data(2), 32'hABCD);
        check("t5 next busy", {31'd0, rs_busy[2]}, 32'd0);

        // 6: random soak
        for (int c = 0; c < 10000; c++) begin
            cyc();
            for (int p = 0; p < NRD; p++) rd_a[p] = AW'($urandom_range(0, NREGS - 1));
            for (int l = 0; l < NWR; l++) begin
                we[l] = 1'($urandom_range(0, 1));
                wa[l] = AW'($urandom_range(0, 15));
                wd[l] = $urandom;
            end
            al_en = 1'($urandom_range(0, 1));
            al_a  = AW'($urandom_range(0, 15));
        end
        cyc();
        idle();
        repeat (2) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
